event_marker_tracker: RTL and testbench
=======================================

EVENT_MARKER_TRACKER -- requirements
Module: event_marker_tracker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the record FIFO entry count (power of two, >=2).
REQ-002 SHALL have parameter TAINT_W, default 32, the width of the taint sum inputs.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enq_valid  input  1  ROB slot-0 enqueue valid.
REQ-006 SHALL have port enq_inst  input  32  ROB slot-0 enqueue debug instruction.
REQ-007 SHALL have port commit_valid  input  1  ROB slot-0 commit valid.
REQ-008 SHALL have port commit_inst  input  32  ROB slot-0 commit debug instruction.
REQ-009 SHALL have port taint_base  input  TAINT_W  base-instance taint sum.
REQ-010 SHALL have port taint_vnt  input  TAINT_W  variant-instance taint sum.
REQ-011 SHALL have port rec_valid  output  1  FIFO head record valid.
REQ-012 SHALL have port rec_ready  input  1  downstream logger accepts head.
REQ-013 SHALL have port rec_id  output  3  marker id (0..7).
REQ-014 SHALL have port rec_commit  output  1  1 = commit-stream record, 0 = enqueue-stream record.
REQ-015 SHALL have port rec_cycle  output  64  cycle stamp of detection.
REQ-016 SHALL have port rec_delta  output  TAINT_W  taint delta at detection (commit END records: phase peak).
REQ-017 SHALL have port phase  output  3  current phase: 0 IDLE, 1 VCTM, 2 DELAY, 3 TEXE, 4 LEAK.
REQ-018 SHALL have port seq_err  output  1  sticky marker-ordering error.
REQ-019 SHALL have port drop_count  output  16  saturating count of records lost to a full FIFO.

Function
REQ-020 Marker SHALL be inst[31:23]==0 and inst[19:0]==20'h02013; id = inst[22:20] (0 VCTM_START, 1 VCTM_END, 2 DELAY_START, 3 DELAY_END, 4 TEXE_START, 5 TEXE_END, 6 LEAK_START, 7 LEAK_END).
REQ-021 A marker SHALL be detected only when its valid is 1; non-marker instructions have no effect.
REQ-022 Cycle counter SHALL be 64 bits, 0 in the first post-reset cycle, +1 per cycle, wrapping at 2^64-1 to 0.
REQ-023 Delta SHALL be |taint_base - taint_vnt| computed unsigned at full TAINT_W without overflow.
REQ-024 A detected marker SHALL push {id, stream, counter, delta} to the FIFO; detected in cycle N -> rec_valid visible at cycle N+1 at earliest.
REQ-025 Handshake: head SHALL pop when rec_valid && rec_ready; rec_* stable while rec_valid && !rec_ready.
REQ-026 Enqueue and commit markers in the same cycle SHALL both push, enqueue record first; with one free slot only the enqueue record is pushed and the commit record is dropped.
REQ-027 Push into a full FIFO SHALL be dropped; a pop in the same cycle frees a slot for that push (full FIFO + pop + one push = no drop).
REQ-028 Each dropped record SHALL increment drop_count by 1 (2 if both dropped), saturating at 16'hFFFF.
REQ-029 Phase FSM SHALL be driven only by commit-stream markers: START id 2k moves to phase k+1 from any state; END id 2k+1 in phase k+1 moves to IDLE.
REQ-030 START while phase != IDLE, or END not matching current phase, SHALL set seq_err; a mismatched END leaves phase unchanged.
REQ-031 Peak register SHALL reset to the current delta on a commit START and track max(peak, delta) each cycle while phase != IDLE.
REQ-032 Commit END records matching the phase SHALL carry max(peak, delta of that cycle) in rec_delta; all other records carry the instantaneous delta.

Reset
REQ-033 On reset SHALL clear: FIFO empty, rec_valid=0, phase=0, seq_err=0, drop_count=0, counter=0, peak=0; rec_id/rec_commit/rec_cycle/rec_delta = 0.
REQ-034 Reset mid-operation SHALL discard all queued records and the phase, taking effect at the next rising edge; the seq_err sticky clears only by reset.

Verification
REQ-035 Commit 32'h00002013 at counter 10, base=7, vnt=3 -> next cycle rec_valid=1, rec_id=0, rec_commit=1, rec_cycle=10, rec_delta=4, phase=1.
REQ-036 In phase 1 delta rises to 9 then falls to 2; commit 32'h00102013 -> rec_id=1, rec_delta=9, phase=0, seq_err=0.
REQ-037 Enq 32'h00402013 and commit 32'h00502013 same cycle in IDLE -> two records in order (id 4, commit 0) then (id 5, commit 1); seq_err=1, phase=0.
REQ-038 rec_ready=0, FIFO_DEPTH=4, six enq markers -> four records held unchanged, drop_count=2; then rec_ready=1 -> four pops in order.
REQ-039 Reset asserted with three queued records and phase=3 -> following cycle rec_valid=0, phase=0, drop_count=0, counter restarts at 0.
REQ-040 Enq 32'h00802013 (inst[23]=1) and 32'h00002033 -> no record, phase unchanged.

Source files
------------

// File: rtl/event_marker_tracker_if.sv
// Record stream from the marker tracker to a downstream logger.
// The master presents the FIFO head; the slave accepts it with rec_ready.
interface event_marker_tracker_if #(
    parameter int TAINT_W = 32
);
    logic               rec_valid;
    logic               rec_ready;
    logic [2:0]         rec_id;
    logic               rec_commit;
    logic [63:0]        rec_cycle;
    logic [TAINT_W-1:0] rec_delta;

    modport master (
        output rec_valid, rec_id, rec_commit, rec_cycle, rec_delta,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_id, rec_commit, rec_cycle, rec_delta,
        output rec_ready
    );
endinterface

// File: rtl/event_marker_tracker.sv
// Detects debug marker instructions on the ROB enqueue/commit streams, stamps them
// with cycle and taint delta, queues them for a logger and tracks the attack phase.
//
// state    | meaning
// PH_IDLE  | no phase open
// PH_VCTM  | victim phase open
// PH_DELAY | delay phase open
// PH_TEXE  | transient-execution phase open
// PH_LEAK  | leak phase open
module event_marker_tracker #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAINT_W    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    input  logic [31:0]            enq_inst,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_inst,
    input  logic [TAINT_W-1:0]     taint_base,
    input  logic [TAINT_W-1:0]     taint_vnt,
    event_marker_tracker_if.master rec,
    output logic [2:0]             phase,
    output logic                   seq_err,
    output logic [15:0]            drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_VCTM  = 3'd1,
        PH_DELAY = 3'd2,
        PH_TEXE  = 3'd3,
        PH_LEAK  = 3'd4
    } phase_e;

    typedef struct packed {
        logic [2:0]         id;
        logic               commit;
        logic [63:0]        cycle;
        logic [TAINT_W-1:0] delta;
    } rec_t;

    rec_t               mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [63:0]        cycle_q;
    phase_e             phase_q;
    logic               seq_err_q;
    logic [15:0]        drop_q, drop_d;
    logic [TAINT_W-1:0] peak_q;

    logic [TAINT_W-1:0] delta, peak_max;
    logic               enq_det, cmt_det, cmt_start, cmt_end, end_match;
    logic [2:0]         cmt_id;
    phase_e             start_phase, end_phase;
    logic               pop, push_enq, push_cmt;
    logic [CW:0]        free_slots;
    logic [1:0]         n_drop;
    logic [16:0]        drop_sum;
    rec_t               enq_rec, cmt_rec, head;

    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[31:23] == 9'd0) && (inst[19:0] == 20'h02013);
    endfunction

    always_comb begin
        delta     = (taint_base >= taint_vnt) ? (taint_base - taint_vnt) : (taint_vnt - taint_base);
        peak_max  = (delta > peak_q) ? delta : peak_q;

        enq_det   = enq_valid && is_marker(enq_inst);
        cmt_det   = commit_valid && is_marker(commit_inst);
        cmt_id    = commit_inst[22:20];
        cmt_start = cmt_det && !cmt_id[0];
        cmt_end   = cmt_det && cmt_id[0];
        // START 2k and END 2k+1 both refer to phase k+1
        start_phase = phase_e'({1'b0, cmt_id[2:1]} + 3'd1);
        end_phase   = start_phase;
        end_match   = cmt_end && (phase_q == end_phase);

        enq_rec = '{id: enq_inst[22:20], commit: 1'b0, cycle: cycle_q, delta: delta};
        cmt_rec = '{id: cmt_id, commit: 1'b1, cycle: cycle_q,
                    delta: (end_match ? peak_max : delta)};

        // a same-cycle pop frees a slot for this cycle's pushes; enqueue stream wins
        pop        = (count_q != '0) && rec.rec_ready;
        free_slots = (CW+1)'(FIFO_DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
        push_enq   = enq_det && (free_slots != '0);
        push_cmt   = cmt_det && (free_slots > {{CW{1'b0}}, push_enq});
        count_d    = count_q + CW'(push_enq) + CW'(push_cmt) - CW'(pop);

        n_drop   = {1'b0, enq_det & ~push_enq} + {1'b0, cmt_det & ~push_cmt};
        drop_sum = {1'b0, drop_q} + {15'd0, n_drop};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            cycle_q   <= '0;
            phase_q   <= PH_IDLE;
            seq_err_q <= 1'b0;
            drop_q    <= '0;
            peak_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            wr_ptr_q <= wr_ptr_q + AW'(push_enq) + AW'(push_cmt);
            count_q  <= count_d;
            cycle_q  <= cycle_q + 64'd1;
            drop_q   <= drop_d;

            if (cmt_start) begin
                phase_q <= start_phase;
                peak_q  <= delta;
                if (phase_q != PH_IDLE) seq_err_q <= 1'b1;
            end else begin
                if (phase_q != PH_IDLE) peak_q <= peak_max;
                if (cmt_end) begin
                    if (end_match) phase_q   <= PH_IDLE;
                    else           seq_err_q <= 1'b1;
                end
            end
        end
    end

    // storage needs no reset: the outputs are masked while the FIFO is empty
    always_ff @(posedge clock) begin
        if (push_enq) mem_q[wr_ptr_q] <= enq_rec;
        if (push_cmt) mem_q[wr_ptr_q + AW'(push_enq)] <= cmt_rec;
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        rec.rec_valid  = (count_q != '0);
        rec.rec_id     = '0;
        rec.rec_commit = 1'b0;
        rec.rec_cycle  = '0;
        rec.rec_delta  = '0;
        if (count_q != '0) begin
            rec.rec_id     = head.id;
            rec.rec_commit = head.commit;
            rec.rec_cycle  = head.cycle;
            rec.rec_delta  = head.delta;
        end
    end

    assign phase      = phase_q;
    assign seq_err    = seq_err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_event_marker_tracker.sv
// Randomised and directed bench for event_marker_tracker with a queue-based
// reference model; a negedge monitor compares every presented record.
module tb_event_marker_tracker;
    localparam int DEPTH = 4;
    localparam int TW    = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          enq_valid, commit_valid;
    logic [31:0]   enq_inst, commit_inst;
    logic [TW-1:0] taint_base, taint_vnt;
    logic [2:0]    phase;
    logic          seq_err;
    logic [15:0]   drop_count;

    event_marker_tracker_if #(.TAINT_W(TW)) rif();

    event_marker_tracker #(.FIFO_DEPTH(DEPTH), .TAINT_W(TW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enq_valid    (enq_valid),
        .enq_inst     (enq_inst),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .taint_base   (taint_base),
        .taint_vnt    (taint_vnt),
        .rec          (rif),
        .phase        (phase),
        .seq_err      (seq_err),
        .drop_count   (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int              id;
        bit              commit;
        longint unsigned cyc;
        longint unsigned delta;
    } exp_t;

    exp_t            exp_q[$];
    int              total = 0;
    int              bad   = 0;
    int              mdl_occ, mdl_phase, mdl_drop;
    bit              mdl_seq;
    longint unsigned mdl_cyc, mdl_peak;
    bit              mon_en = 1'b0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_mk(input logic [31:0] inst);
        return (inst[31:23] == 9'd0) && (inst[19:0] == 20'h02013);
    endfunction

    function automatic logic [31:0] mk(input int id);
        return 32'h00002013 | (32'(id & 7) << 20);
    endfunction

    // One clock cycle: drive inputs, let the edge happen, then advance the model
    task automatic cycle(input bit r, input bit ev, input logic [31:0] ei,
                         input bit cv, input logic [31:0] ci,
                         input logic [31:0] b, input logic [31:0] v, input bit rd);
        longint unsigned d, pk;
        bit em, cm, cstart, cend, match, popm;
        int cid, free;
        reset = r; enq_valid = ev; enq_inst = ei; commit_valid = cv; commit_inst = ci;
        taint_base = b; taint_vnt = v; rif.rec_ready = rd;
        @(posedge clock);
        if (r) begin
            mdl_occ = 0; exp_q.delete(); mdl_phase = 0; mdl_seq = 0;
            mdl_drop = 0; mdl_cyc = 0; mdl_peak = 0; mon_en = 1'b1;
        end else begin
            d      = (b >= v) ? longint'(b) - longint'(v) : longint'(v) - longint'(b);
            pk     = (d > mdl_peak) ? d : mdl_peak;
            em     = ev && is_mk(ei);
            cm     = cv && is_mk(ci);
            cid    = int'(ci[22:20]);
            cstart = cm && (cid % 2 == 0);
            cend   = cm && (cid % 2 == 1);
            match  = cend && (mdl_phase == cid / 2 + 1);
            popm   = rd && (mdl_occ > 0);
            free   = DEPTH - mdl_occ + (popm ? 1 : 0);
            if (popm) mdl_occ--;
            if (em) begin
                if (free > 0) begin
                    exp_q.push_back('{id: int'(ei[22:20]), commit: 1'b0, cyc: mdl_cyc, delta: d});
                    free--; mdl_occ++;
                end else if (mdl_drop < 65535) mdl_drop++;
            end
            if (cm) begin
                if (free > 0) begin
                    exp_q.push_back('{id: cid, commit: 1'b1, cyc: mdl_cyc, delta: (match ? pk : d)});
                    mdl_occ++;
                end else if (mdl_drop < 65535) mdl_drop++;
            end
            if (cstart) begin
                if (mdl_phase != 0) mdl_seq = 1;
                mdl_phase = cid / 2 + 1;
                mdl_peak  = d;
            end else begin
                if (mdl_phase != 0) mdl_peak = pk;
                if (cend) begin
                    if (match) mdl_phase = 0;
                    else       mdl_seq = 1;
                end
            end
            mdl_cyc++;
        end
        #1;
    endtask

    task automatic idle(input bit rd);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, rd);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("rec_valid", rif.rec_valid, mdl_occ > 0);
            chk("phase", phase, mdl_phase);
            chk("seq_err", seq_err, mdl_seq);
            chk("drop_count", drop_count, mdl_drop);
            if (rif.rec_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_record: got id %0d, expected none", rif.rec_id);
                end else begin
                    chk("rec_id", rif.rec_id, exp_q[0].id);
                    chk("rec_commit", rif.rec_commit, exp_q[0].commit);
                    chk("rec_cycle", rif.rec_cycle, exp_q[0].cyc);
                    chk("rec_delta", rif.rec_delta, exp_q[0].delta);
                    if (rif.rec_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] ei, ci;
        rif.rec_ready = 1'b0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset_valid", rif.rec_valid, 0);
        chk("reset_id", rif.rec_id, 0);
        chk("reset_commit", rif.rec_commit, 0);
        chk("reset_cycle", rif.rec_cycle, 0);
        chk("reset_delta", rif.rec_delta, 0);
        chk("reset_phase", phase, 0);
        chk("reset_drop", drop_count, 0);

        // VCTM_START at counter 10
        for (int i = 0; i < 10; i++) idle(1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h00002013, 32'd7, 32'd3, 1'b1);
        chk("start_valid", rif.rec_valid, 1);
        chk("start_id", rif.rec_id, 0);
        chk("start_commit", rif.rec_commit, 1);
        chk("start_cycle", rif.rec_cycle, 10);
        chk("start_delta", rif.rec_delta, 4);
        chk("start_phase", phase, 1);

        // peak 9 carried by the matching END
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd9, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd2, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h00102013, 32'd0, 32'd2, 1'b1);
        chk("end_id", rif.rec_id, 1);
        chk("end_delta", rif.rec_delta, 9);
        chk("end_phase", phase, 0);
        chk("end_seq_err", seq_err, 0);
        idle(1'b1);

        // simultaneous enqueue + commit markers, commit END out of order
        cycle(1'b0, 1'b1, 32'h00402013, 1'b1, 32'h00502013, 32'd1, 32'd1, 1'b0);
        chk("dual_first_id", rif.rec_id, 4);
        chk("dual_first_commit", rif.rec_commit, 0);
        chk("dual_seq_err", seq_err, 1);
        chk("dual_phase", phase, 0);
        idle(1'b1);
        chk("dual_second_id", rif.rec_id, 5);
        chk("dual_second_commit", rif.rec_commit, 1);
        idle(1'b1);
        idle(1'b1);

        // overflow: six enqueue markers into a stalled FIFO
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, mk(i), 1'b0, 32'h0, 32'(i), 32'd0, 1'b0);
        chk("ovf_drop", drop_count, 2);
        for (int i = 0; i < 3; i++) idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", rif.rec_id, i);
            idle(1'b1);
        end
        chk("ovf_empty", rif.rec_valid, 0);

        // reset with three queued records and phase TEXE
        cycle(1'b0, 1'b1, 32'h00002013, 1'b1, 32'h00402013, 32'd5, 32'd1, 1'b0);
        cycle(1'b0, 1'b1, 32'h00102013, 1'b0, 32'h0, 32'd5, 32'd1, 1'b0);
        chk("pre_rst_phase", phase, 3);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
        chk("rst_valid", rif.rec_valid, 0);
        chk("rst_phase", phase, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_seq_err", seq_err, 0);
        cycle(1'b0, 1'b1, 32'h00302013, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
        chk("rst_cycle", rif.rec_cycle, 0);
        idle(1'b1);

        // near-miss encodings while LEAK is open
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h00602013, 32'd3, 32'd8, 1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b1, 32'h00802013, 1'b1, 32'h00802013, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h00002033, 1'b1, 32'h00002033, 32'd0, 32'd0, 1'b1);
        chk("nonmk_valid", rif.rec_valid, 0);
        chk("nonmk_phase", phase, 4);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h00702013, 32'd0, 32'd0, 1'b1);
        idle(1'b1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    ei = mk(int'($urandom_range(0, 7)));
                2:       ei = mk(int'($urandom_range(0, 7))) ^ (32'd1 << $urandom_range(0, 31));
                default: ei = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0, 1:    ci = mk(int'($urandom_range(0, 7)));
                2:       ci = mk(int'($urandom_range(0, 7))) ^ (32'd1 << $urandom_range(0, 31));
                default: ci = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0)
                cycle($urandom_range(0, 299) == 0, 1'($urandom), ei, 1'($urandom), ci,
                      $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3) != 0);
            else
                cycle($urandom_range(0, 299) == 0, 1'($urandom), ei, 1'($urandom), ci,
                      $urandom, $urandom, $urandom_range(0, 3) != 0);
        end

        // drop counter saturation
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
        for (int n = 0; n < 32800; n++)
            cycle(1'b0, 1'b1, 32'h00102013, 1'b1, 32'h00102013, 32'd1, 32'd0, 1'b0);
        chk("drop_sat", drop_count, 16'hFFFF);
        for (int n = 0; n < 6; n++) idle(1'b1);
        chk("final_empty", rif.rec_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
